// File: rtl/nr_dmrs_pkg.sv
// rtl/nr_dmrs_pkg.sv - shared constants and FSM state type for the DMRS hypothesis scheduler
package nr_dmrs_pkg;

  localparam int NUM_HYP  = 8;
  localparam int DMRS_SYM = 144;
  localparam int WDOG_MAX = 4095;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_WAIT_MET,
    S_NEXT,
    S_FIN
  } state_e;

endpackage

// File: rtl/dmrs_metric_max.sv
// rtl/dmrs_metric_max.sv - running maximum of correlator metrics across one hypothesis sweep
module dmrs_metric_max
  import nr_dmrs_pkg::*;
#(
  parameter int MW = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       upd_i,
  input  logic                       first_i,
  input  logic [$clog2(NUM_HYP)-1:0] hyp_i,
  input  logic [MW-1:0]              metric_i,
  output logic [1:0]                 best_issb_o,
  output logic                       best_n_hf_o,
  output logic [MW-1:0]              best_metric_o
);

  logic [1:0]    best_issb_q;
  logic          best_n_hf_q;
  logic [MW-1:0] best_metric_q;

  // Strict compare: on a tie the earlier (lower) hypothesis is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_issb_q   <= '0;
      best_n_hf_q   <= 1'b0;
      best_metric_q <= '0;
    end else if (upd_i && (first_i || (metric_i > best_metric_q))) begin
      best_issb_q   <= hyp_i[1:0];
      best_n_hf_q   <= hyp_i[2];
      best_metric_q <= metric_i;
    end
  end

  assign best_issb_o   = best_issb_q;
  assign best_n_hf_o   = best_n_hf_q;
  assign best_metric_o = best_metric_q;

endmodule

// File: rtl/dmrs_hyp_sched.sv
// rtl/dmrs_hyp_sched.sv - sweeps 8 issb/n_hf DMRS hypotheses and reports the best metric
// Optional watchdog abort in RUN/WAIT_MET when DMRS_SCHED_TIMEOUT_EN is defined.
module dmrs_hyp_sched
  import nr_dmrs_pkg::*;
#(
  parameter int MW   = 24,
  parameter int NHYP = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [9:0]    ncellid,
  output logic          gen_start,
  output logic [1:0]    gen_issb,
  output logic          gen_n_hf,
  output logic [9:0]    gen_ncellid,
  input  logic          gen_valid,
  input  logic          gen_done,
  input  logic [MW-1:0] metric,
  input  logic          metric_valid,
  output logic [1:0]    best_issb,
  output logic          best_n_hf,
  output logic [MW-1:0] best_metric,
  output logic          result_valid,
  output logic          busy,
  output logic          err
);

  localparam logic [2:0] H_LAST = 3'(NHYP - 1);

  state_e     state_q;
  logic [2:0] h_q;
  logic [9:0] ncellid_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       pend_q;
  logic       gen_start_q;
  logic       result_valid_q;
  logic       busy_q;
  logic       err_q;
  logic       upd;
`ifdef DMRS_SCHED_TIMEOUT_EN
  logic [11:0] wdog_q;
`endif

  // The symbol that arrives alongside gen_done still belongs to this hypothesis.
  assign cnt_d = cnt_q + {7'd0, gen_valid};
  assign upd   = (state_q == S_WAIT_MET) && metric_valid;

  // pend_q adds one IDLE cycle between acceptance and LAUNCH, so that start and
  // metric_valid both reach the next gen_start in two cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      h_q            <= '0;
      ncellid_q      <= '0;
      cnt_q          <= '0;
      pend_q         <= 1'b0;
      gen_start_q    <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
`ifdef DMRS_SCHED_TIMEOUT_EN
      wdog_q         <= '0;
`endif
    end else begin
      gen_start_q    <= 1'b0;
      result_valid_q <= 1'b0;
`ifdef DMRS_SCHED_TIMEOUT_EN
      if (state_q == S_LAUNCH || (state_q == S_RUN && gen_done)) wdog_q <= '0;
      else wdog_q <= wdog_q + 12'd1;
`endif
      case (state_q)
        S_IDLE: begin
          if (pend_q) begin
            pend_q      <= 1'b0;
            state_q     <= S_LAUNCH;
            gen_start_q <= 1'b1;
          end else if (start) begin
            ncellid_q <= ncellid;
            h_q       <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            pend_q    <= 1'b1;
          end
        end
        S_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (gen_done) begin
            if (cnt_d != 8'(DMRS_SYM)) err_q <= 1'b1;
            state_q <= S_WAIT_MET;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WAIT_MET: begin
          if (metric_valid) state_q <= S_NEXT;
        end
        S_NEXT: begin
          if (h_q == H_LAST) begin
            state_q        <= S_FIN;
            result_valid_q <= 1'b1;
            busy_q         <= 1'b0;
          end else begin
            h_q         <= h_q + 3'd1;
            state_q     <= S_LAUNCH;
            gen_start_q <= 1'b1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
`ifdef DMRS_SCHED_TIMEOUT_EN
      // The 4095th cycle spent waiting ends the sweep with whatever best was found.
      if ((state_q == S_RUN || state_q == S_WAIT_MET) && wdog_q == 12'(WDOG_MAX - 1)) begin
        err_q          <= 1'b1;
        state_q        <= S_FIN;
        result_valid_q <= 1'b1;
        busy_q         <= 1'b0;
      end
`endif
    end
  end

  dmrs_metric_max #(
    .MW (MW)
  ) u_max (
    .clk           (clk),
    .rst           (rst),
    .upd_i         (upd),
    .first_i       (h_q == 3'd0),
    .hyp_i         (h_q),
    .metric_i      (metric),
    .best_issb_o   (best_issb),
    .best_n_hf_o   (best_n_hf),
    .best_metric_o (best_metric)
  );

  assign gen_start    = gen_start_q;
  assign gen_issb     = h_q[1:0];
  assign gen_n_hf     = h_q[2];
  assign gen_ncellid  = ncellid_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule
